// File: rtl/packet_checker_pkg.sv
// rtl/packet_checker_pkg.sv - shared constants, register map and header layout for the packet generator/checker pair
package packet_checker_pkg;

  localparam logic [31:0] PKTCHK_ID         = 32'h504B4348;
  localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

  // Header byte offsets within a generator frame
  localparam int HDR_ETHERTYPE_OFF = 12;
  localparam int HDR_FLOW_OFF      = 14;
  localparam int HDR_SEQ_OFF       = 16;

  localparam int REG_ID          = 'h000;
  localparam int REG_CTRL        = 'h004;
  localparam int REG_BAD_CNT     = 'h008;
  localparam int REG_FOREIGN_CNT = 'h00C;
  localparam int REG_FLOW_BASE   = 'h100;
  localparam int REG_FLOW_STRIDE = 16;
  localparam int REG_FLOW_PKTS     = 'h0;
  localparam int REG_FLOW_BYTES    = 'h4;
  localparam int REG_FLOW_SEQ_ERR  = 'h8;
  localparam int REG_FLOW_LAST_SEQ = 'hC;

  typedef enum logic [1:0] {
    ST_BEAT0,
    ST_BEAT1,
    ST_BEAT2,
    ST_BODY
  } parse_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/packet_checker_axil_regs.sv
// rtl/packet_checker_axil_regs.sv - AXI-Lite handshake, CTRL register and counter read mux
module packet_checker_axil_regs
  import packet_checker_pkg::*;
#(
  parameter int N_FLOWS         = 2,
  parameter int AXIL_ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXIL_ADDR_WIDTH-1:0]      s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [31:0]                     s_axil_wdata,
  input  logic [3:0]                      s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]      s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [31:0]                     s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic                            ctrl_enable,
  output logic                            ctrl_clear,
  input  logic [31:0]                     bad_cnt,
  input  logic [31:0]                     foreign_cnt,
  input  logic [N_FLOWS-1:0][31:0]        pkt_cnt,
  input  logic [N_FLOWS-1:0][31:0]        byte_cnt,
  input  logic [N_FLOWS-1:0][31:0]        seq_err_cnt,
  input  logic [N_FLOWS-1:0][31:0]        last_seq
);

  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int FW = AXIL_ADDR_WIDTH - 4;

  logic        wr_fire;
  logic        wr_ctrl;
  logic        rd_fire;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign wr_fire      = s_axil_awready & s_axil_awvalid & s_axil_wvalid;
  assign wr_ctrl      = wr_fire && (s_axil_awaddr == AW'(REG_CTRL)) && s_axil_wstrb[0];
  assign ctrl_clear   = wr_ctrl & s_axil_wdata[1];
  assign rd_fire      = s_axil_arready & s_axil_arvalid;
  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;
  assign unused_ok    = ^{s_axil_awprot, s_axil_arprot, s_axil_wdata[31:2], s_axil_wstrb[3:1]};

  always_comb begin
    rd_mux = '0;
    if (s_axil_araddr == AW'(REG_ID))               rd_mux = PKTCHK_ID;
    else if (s_axil_araddr == AW'(REG_CTRL))        rd_mux = {31'b0, ctrl_enable};
    else if (s_axil_araddr == AW'(REG_BAD_CNT))     rd_mux = bad_cnt;
    else if (s_axil_araddr == AW'(REG_FOREIGN_CNT)) rd_mux = foreign_cnt;
    // Each flow owns one 16-byte window above the flow base
    for (int f = 0; f < N_FLOWS; f++) begin
      if (s_axil_araddr[AW-1:4] == FW'(REG_FLOW_BASE / REG_FLOW_STRIDE + f)) begin
        case (s_axil_araddr[3:0])
          4'(REG_FLOW_PKTS):     rd_mux = pkt_cnt[f];
          4'(REG_FLOW_BYTES):    rd_mux = byte_cnt[f];
          4'(REG_FLOW_SEQ_ERR):  rd_mux = seq_err_cnt[f];
          4'(REG_FLOW_LAST_SEQ): rd_mux = last_seq[f];
          default:               rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      ctrl_enable    <= 1'b0;
    end else begin
      s_axil_awready <= s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid & ~s_axil_awready;
      s_axil_wready  <= s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid & ~s_axil_awready;
      if (wr_fire)            s_axil_bvalid <= 1'b1;
      else if (s_axil_bready) s_axil_bvalid <= 1'b0;
      if (wr_ctrl) ctrl_enable <= s_axil_wdata[0];
      s_axil_arready <= s_axil_arvalid & ~s_axil_rvalid & ~s_axil_arready;
      if (rd_fire) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_mux;
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/packet_checker_64.sv
// rtl/packet_checker_64.sv - 64-bit RX frame parser with per-flow counters; PKTCHK_SEQ_CHECK_EN adds sequence checking
module packet_checker_64
  import packet_checker_pkg::*;
#(
  parameter int          N_FLOWS         = 2,
  parameter logic [15:0] ETHERTYPE       = DEFAULT_ETHERTYPE,
  parameter int          AXIL_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                s_axis_tdata,
  input  logic [7:0]                 s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tuser,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [31:0]                s_axil_wdata,
  input  logic [3:0]                 s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [31:0]                s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready
);

  localparam logic [7:0] N_FLOWS_B = 8'(N_FLOWS);
  localparam int ETH_LANE  = HDR_ETHERTYPE_OFF % 8;
  localparam int FLOW_LANE = HDR_FLOW_OFF % 8;
  localparam int SEQ_LANE  = HDR_SEQ_OFF % 8;

  parse_state_t state, state_next;

  logic        ctrl_enable, ctrl_clear;
  logic        en_q;
  logic [15:0] eth_q, eth_cur, eth_eff;
  logic [7:0]  flow_q, flow_cur, flow_eff;
  logic [31:0] seq_q, seq_cur, seq_eff;
  logic [15:0] len_q, len_base, len_eff;
  logic        frame_en, early_end, is_foreign, commit, commit_good;
  logic        unused_ok;

  logic [31:0]              bad_cnt, foreign_cnt;
  logic [N_FLOWS-1:0][31:0] pkt_cnt, byte_cnt, seq_err_cnt, last_seq;

  assign s_axis_tready = 1'b1;
  assign unused_ok     = ^s_axis_tdata;

  // Header fields as they appear on the current beat; multi-byte fields are big-endian on the wire
  assign eth_cur  = {s_axis_tdata[ETH_LANE*8 +: 8], s_axis_tdata[(ETH_LANE+1)*8 +: 8]};
  assign flow_cur = s_axis_tdata[FLOW_LANE*8 +: 8];
  assign seq_cur  = {s_axis_tdata[SEQ_LANE*8 +: 8], s_axis_tdata[(SEQ_LANE+1)*8 +: 8],
                     s_axis_tdata[(SEQ_LANE+2)*8 +: 8], s_axis_tdata[(SEQ_LANE+3)*8 +: 8]};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BEAT0;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        state_next = ST_BEAT0;
      end else begin
        case (state)
          ST_BEAT0: state_next = ST_BEAT1;
          ST_BEAT1: state_next = ST_BEAT2;
          default:  state_next = ST_BODY;
        endcase
      end
    end
  end

  // Merge latched header fields with the current beat so a tlast on any beat commits in that cycle
  always_comb begin
    frame_en  = en_q;
    eth_eff   = eth_q;
    flow_eff  = flow_q;
    seq_eff   = seq_q;
    len_base  = len_q;
    early_end = 1'b0;
    case (state)
      ST_BEAT0: begin
        frame_en  = ctrl_enable;
        len_base  = '0;
        early_end = 1'b1;
      end
      ST_BEAT1: begin
        eth_eff   = eth_cur;
        flow_eff  = flow_cur;
        early_end = 1'b1;
      end
      ST_BEAT2: seq_eff = seq_cur;
      default: ;
    endcase
  end

  assign len_eff     = len_base + {12'b0, popcount8(s_axis_tkeep)};
  assign commit      = s_axis_tvalid & s_axis_tlast & frame_en;
  assign is_foreign  = early_end | (eth_eff != ETHERTYPE) | (flow_eff >= N_FLOWS_B);
  assign commit_good = commit & ~s_axis_tuser & ~is_foreign;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      len_q  <= '0;
      eth_q  <= '0;
      flow_q <= '0;
      seq_q  <= '0;
    end else if (s_axis_tvalid) begin
      len_q <= len_eff;
      if (state == ST_BEAT0) en_q <= ctrl_enable;
      if (state == ST_BEAT1) begin
        eth_q  <= eth_cur;
        flow_q <= flow_cur;
      end
      if (state == ST_BEAT2) seq_q <= seq_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) begin
      bad_cnt     <= '0;
      foreign_cnt <= '0;
      pkt_cnt     <= '0;
      byte_cnt    <= '0;
      last_seq    <= '0;
    end else if (commit) begin
      if (s_axis_tuser) begin
        bad_cnt <= sat_inc32(bad_cnt);
      end else if (is_foreign) begin
        foreign_cnt <= sat_inc32(foreign_cnt);
      end else begin
        for (int f = 0; f < N_FLOWS; f++) begin
          if (flow_eff == 8'(f)) begin
            pkt_cnt[f]  <= pkt_cnt[f] + 32'd1;
            byte_cnt[f] <= byte_cnt[f] + {16'b0, len_eff};
            last_seq[f] <= seq_eff;
          end
        end
      end
    end
  end

`ifdef PKTCHK_SEQ_CHECK_EN
  logic [N_FLOWS-1:0][31:0] exp_seq;
  logic [N_FLOWS-1:0]       synced;

  always_ff @(posedge clk) begin
    if (rst || ctrl_clear) begin
      exp_seq     <= '0;
      synced      <= '0;
      seq_err_cnt <= '0;
    end else if (commit_good) begin
      for (int f = 0; f < N_FLOWS; f++) begin
        if (flow_eff == 8'(f)) begin
          if (synced[f] && (seq_eff != exp_seq[f])) seq_err_cnt[f] <= sat_inc32(seq_err_cnt[f]);
          exp_seq[f] <= seq_eff + 32'd1;
          synced[f]  <= 1'b1;
        end
      end
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

  packet_checker_axil_regs #(
    .N_FLOWS        (N_FLOWS),
    .AXIL_ADDR_WIDTH(AXIL_ADDR_WIDTH)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awprot (s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .s_axil_araddr (s_axil_araddr),
    .s_axil_arprot (s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready),
    .ctrl_enable   (ctrl_enable),
    .ctrl_clear    (ctrl_clear),
    .bad_cnt       (bad_cnt),
    .foreign_cnt   (foreign_cnt),
    .pkt_cnt       (pkt_cnt),
    .byte_cnt      (byte_cnt),
    .seq_err_cnt   (seq_err_cnt),
    .last_seq      (last_seq)
  );

endmodule
